l1_cache_ctrl: RTL and testbench

- Blocking, set-associative, write-back, write-allocate L1 data cache.
- Sits between the CPU, which issues byte reads and writes, and the L2 cache, which transfers whole L1 blocks.
- Serves one CPU request at a time.
- On a miss it evicts a victim block (writing it back to L2 if dirty), fills the line from L2, then completes the request.

---
 rtl/l1_cache_pkg.sv | 28 ++
 rtl/l1_tag_match.sv | 30 +++
 rtl/l1_cache_ctrl.sv | 140 ++++++++++++++
 tb/tb_l1_cache_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: shared geometry, FSM states and address-field helpers for the L1 data cache
package l1_cache_pkg;
  localparam int L1_ADDR_W  = 11;
  localparam int L1_DATA_W  = 8;
  localparam int L1_CACHE_B = 256;
  localparam int L1_BLOCK_B = 16;
  localparam int L1_WAYS    = 8;
  localparam int NUM_SETS   = L1_CACHE_B / L1_BLOCK_B / L1_WAYS;
  localparam int OFF_W      = $clog2(L1_BLOCK_B);
  localparam int IDX_W      = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int TAG_W      = L1_ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W      = $clog2(L1_WAYS);
  localparam int LINE_W     = L1_BLOCK_B * L1_DATA_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;

  function automatic logic [OFF_W-1:0] addr_off(input logic [L1_ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [L1_ADDR_W-1:0] a);
    return a[OFF_W+IDX_W-1:OFF_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [L1_ADDR_W-1:0] a);
    return a[L1_ADDR_W-1:OFF_W+IDX_W];
  endfunction
endpackage

// File: rtl/l1_tag_match.sv
// l1_tag_match: compares a tag against one set and finds the lowest-index free way
module l1_tag_match
  import l1_cache_pkg::*;
(
  input  logic [TAG_W-1:0]                tag,
  input  logic [L1_WAYS-1:0]              valid,
  input  logic [L1_WAYS-1:0][TAG_W-1:0]   tags,
  output logic                            hit,
  output logic [WAY_W-1:0]                hit_way,
  output logic                            any_invalid,
  output logic [WAY_W-1:0]                first_invalid_way
);
  // scan downward so the last assignment is the lowest matching/free index
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    any_invalid = 1'b0;
    first_invalid_way = '0;
    for (int w = L1_WAYS - 1; w >= 0; w--) begin
      if (valid[w] && tags[w] == tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[w]) begin
        any_invalid = 1'b1;
        first_invalid_way = WAY_W'(w);
      end
    end
  end
endmodule

// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl: blocking set-associative write-back write-allocate L1 data cache
module l1_cache_ctrl
  import l1_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = L1_ADDR_W,
  parameter int DATA_WIDTH = L1_DATA_W,
  parameter int CACHE_SIZE = L1_CACHE_B,
  parameter int BLOCK_SIZE = L1_BLOCK_B,
  parameter int NUM_WAYS   = L1_WAYS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_data_in,
  input  logic                             cpu_read,
  input  logic                             cpu_write,
  output logic [DATA_WIDTH-1:0]            cpu_data_out,
  output logic                             cpu_ready,
  output logic                             l1_hit,
  output logic [ADDR_WIDTH-1:0]            l2_cache_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_cache_data_out,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_cache_data_in,
  output logic                             l2_cache_read,
  output logic                             l2_cache_write,
  input  logic                             l2_cache_ready,
  input  logic                             l2_cache_hit
);
  state_t state;
  logic [NUM_SETS-1:0][L1_WAYS-1:0] valid;
  logic [NUM_SETS-1:0][L1_WAYS-1:0] dirty;
  logic [NUM_SETS-1:0][L1_WAYS-1:0][TAG_W-1:0] tags;
  logic [LINE_W-1:0] data [NUM_SETS][L1_WAYS];
  logic [NUM_SETS-1:0][WAY_W-1:0] rr_ptr;
  logic [L1_ADDR_W-1:0] req_addr;
  logic [L1_DATA_W-1:0] req_data;
  logic req_wr;
  logic [WAY_W-1:0] victim;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [OFF_W-1:0] off;
  logic hit, any_invalid, do_access;
  logic [WAY_W-1:0] hit_way, first_invalid_way, vic, acc_way;
  logic [LINE_W-1:0] line;
  logic [L1_DATA_W-1:0] rd_byte;
  logic unused_l2_hit;

  assign unused_l2_hit = l2_cache_hit;
  assign idx = addr_idx(req_addr);
  assign tag = addr_tag(req_addr);
  assign off = addr_off(req_addr);
  assign vic = any_invalid ? first_invalid_way : rr_ptr[idx];
  assign acc_way = (state == LOOKUP) ? hit_way : victim;
  assign do_access = (state == LOOKUP && hit) || state == RESPOND;
  assign line = data[idx][acc_way];
  assign rd_byte = line[off*L1_DATA_W +: L1_DATA_W];

  l1_tag_match u_match (
    .tag(tag),
    .valid(valid[idx]),
    .tags(tags[idx]),
    .hit(hit),
    .hit_way(hit_way),
    .any_invalid(any_invalid),
    .first_invalid_way(first_invalid_way)
  );

  // request FSM with registered CPU/L2 outputs; also owns the tag/data/state arrays
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      rr_ptr <= '0;
      cpu_ready <= 1'b0;
      l1_hit <= 1'b0;
      cpu_data_out <= '0;
      l2_cache_read <= 1'b0;
      l2_cache_write <= 1'b0;
      l2_cache_addr <= '0;
      l2_cache_data_out <= '0;
    end else begin
      if (do_access) begin
        if (req_wr) begin
          data[idx][acc_way][off*L1_DATA_W +: L1_DATA_W] <= req_data;
          dirty[idx][acc_way] <= 1'b1;
        end else begin
          cpu_data_out <= rd_byte;
        end
      end
      case (state)
        IDLE: if (cpu_read || cpu_write) begin
          req_addr <= cpu_addr;
          req_data <= cpu_data_in;
          req_wr <= cpu_write;
          cpu_ready <= 1'b0;
          l1_hit <= 1'b0;
          state <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          cpu_ready <= 1'b1;
          l1_hit <= 1'b1;
          state <= IDLE;
        end else begin
          victim <= vic;
          rr_ptr[idx] <= (rr_ptr[idx] == WAY_W'(L1_WAYS - 1)) ? '0 : rr_ptr[idx] + 1'b1;
          if (valid[idx][vic] && dirty[idx][vic]) begin
            l2_cache_write <= 1'b1;
            l2_cache_addr <= {tags[idx][vic], idx, OFF_W'(0)};
            l2_cache_data_out <= data[idx][vic];
            state <= WRITEBACK;
          end else begin
            l2_cache_read <= 1'b1;
            l2_cache_addr <= {tag, idx, OFF_W'(0)};
            state <= FILL;
          end
        end
        WRITEBACK: if (l2_cache_ready) begin
          l2_cache_write <= 1'b0;
          l2_cache_read <= 1'b1;
          l2_cache_addr <= {tag, idx, OFF_W'(0)};
          state <= FILL;
        end
        FILL: if (l2_cache_ready) begin
          l2_cache_read <= 1'b0;
          data[idx][victim] <= l2_cache_data_in;
          valid[idx][victim] <= 1'b1;
          tags[idx][victim] <= tag;
          dirty[idx][victim] <= 1'b0;
          state <= RESPOND;
        end
        RESPOND: begin
          cpu_ready <= 1'b1;
          l1_hit <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_cache_ctrl.sv
// tb_l1_cache_ctrl: directed and random checks of l1_cache_ctrl against a byte memory model
module tb_l1_cache_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [10:0] cpu_addr;
  logic [7:0] cpu_data_in;
  logic cpu_read, cpu_write;
  logic [7:0] cpu_data_out;
  logic cpu_ready, l1_hit;
  logic [10:0] l2_addr;
  logic [127:0] l2_data_out;
  logic [127:0] l2_data_in;
  logic l2_read, l2_write;
  logic l2_ready;
  logic l2_hit;

  logic [7:0] l2mem [2048];
  logic [7:0] refm [2048];
  int checks = 0, errors = 0;
  int lat = 1, cnt = 0, seq = 0;
  int n_rd = 0, n_wr = 0, rd_seq = 0, wr_seq = 0;
  logic [10:0] last_rd_addr, last_wr_addr;
  logic [127:0] last_wr_data;
  int cyc, b_rd, b_wr;

  always #5 clk = ~clk;

  l1_cache_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in),
    .cpu_read(cpu_read),
    .cpu_write(cpu_write),
    .cpu_data_out(cpu_data_out),
    .cpu_ready(cpu_ready),
    .l1_hit(l1_hit),
    .l2_cache_addr(l2_addr),
    .l2_cache_data_out(l2_data_out),
    .l2_cache_data_in(l2_data_in),
    .l2_cache_read(l2_read),
    .l2_cache_write(l2_write),
    .l2_cache_ready(l2_ready),
    .l2_cache_hit(l2_hit)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // L2 stub: answers a strobe after lat cycles with a one-cycle ready pulse
  always @(negedge clk) begin
    if (l2_ready) l2_ready = 1'b0;
    else if (rst_n || !(l2_read || l2_write)) cnt = 0;
    else begin
      cnt++;
      if (cnt >= lat) begin
        cnt = 0;
        l2_ready = 1'b1;
        seq++;
        if (l2_write) begin
          n_wr++;
          wr_seq = seq;
          last_wr_addr = l2_addr;
          last_wr_data = l2_data_out;
          for (int i = 0; i < 16; i++) l2mem[{l2_addr[10:4], 4'h0} + 11'(i)] = l2_data_out[i*8 +: 8];
        end else begin
          n_rd++;
          rd_seq = seq;
          last_rd_addr = l2_addr;
          for (int i = 0; i < 16; i++) l2_data_in[i*8 +: 8] = l2mem[{l2_addr[10:4], 4'h0} + 11'(i)];
        end
      end
    end
  end

  always @(negedge clk) chk("l2_excl", l2_read & l2_write, 0);

  task automatic cpu_op(input logic wr, input logic [10:0] a, input logic [7:0] d, output int c);
    @(negedge clk);
    cpu_addr = a;
    cpu_data_in = d;
    cpu_write = wr;
    cpu_read = !wr;
    if (wr) refm[a] = d;
    @(posedge clk);
    c = 1;
    #1 cpu_read = 1'b0;
    cpu_write = 1'b0;
    while (!cpu_ready && c < 200) begin
      @(posedge clk);
      c++;
      #1;
    end
    chk("ready", cpu_ready, 1);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) begin
      l2mem[a] = 8'((a & 15) + 64 + ((a >> 4) - 18) * 13);
      refm[a] = l2mem[a];
    end
    l2_ready = 1'b0;
    l2_hit = 1'b0;
    l2_data_in = '0;
    cpu_addr = '0;
    cpu_data_in = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_hit", l1_hit, 0);
    chk("rst_dout", cpu_data_out, 0);
    chk("rst_l2rd", l2_read, 0);
    chk("rst_l2wr", l2_write, 0);
    chk("rst_l2addr", l2_addr, 0);
    chk("rst_l2data", l2_data_out, 0);
    @(negedge clk) rst_n = 1'b0;

    cpu_op(0, 11'h123, 0, cyc);
    chk("cold_nrd", n_rd, 1);
    chk("cold_nwr", n_wr, 0);
    chk("cold_l2addr", last_rd_addr, 11'h120);
    chk("cold_data", cpu_data_out, 8'h43);
    chk("cold_hit", l1_hit, 0);

    cpu_op(0, 11'h12A, 0, cyc);
    chk("hit_lat", cyc, 2);
    chk("hit_data", cpu_data_out, 8'h4A);
    chk("hit_flag", l1_hit, 1);
    chk("hit_nrd", n_rd, 1);
    chk("hit_nwr", n_wr, 0);

    cpu_op(1, 11'h125, 8'hAB, cyc);
    chk("wr_hit", l1_hit, 1);
    chk("wr_dout_held", cpu_data_out, 8'h4A);
    cpu_op(0, 11'h125, 0, cyc);
    chk("wr_rd_data", cpu_data_out, 8'hAB);
    chk("wr_dirty", dut.dirty[0][0], 1);

    cpu_op(1, 11'h010, 8'h5A, cyc);
    chk("wa_hit", l1_hit, 0);
    chk("wa_nrd", n_rd, 2);
    chk("wa_dirty", dut.dirty[1][0], 1);
    for (int t = 1; t < 8; t++) begin
      cpu_op(0, 11'(t * 32 + 16), 0, cyc);
      chk("set_fill", cpu_data_out, refm[t * 32 + 16]);
    end
    chk("set_full", dut.valid[1], 8'hFF);
    b_wr = n_wr;
    b_rd = n_rd;
    cpu_op(0, 11'h110, 0, cyc);
    chk("ev_nwr", n_wr, b_wr + 1);
    chk("ev_nrd", n_rd, b_rd + 1);
    chk("ev_wb_addr", last_wr_addr, 11'h010);
    chk("ev_wb_byte", last_wr_data[7:0], 8'h5A);
    chk("ev_order", wr_seq < rd_seq, 1);
    chk("ev_rd_addr", last_rd_addr, 11'h110);
    chk("ev_data", cpu_data_out, refm[11'h110]);
    chk("ev_hit", l1_hit, 0);

    lat = 30;
    @(negedge clk);
    cpu_addr = 11'h150;
    cpu_read = 1'b1;
    @(posedge clk);
    #1 cpu_read = 1'b0;
    for (int i = 0; i < 10 && !l2_read; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_fill", l2_read, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_rd", l2_read, 0);
    chk("abort_wr", l2_write, 0);
    chk("abort_valid", dut.valid, 0);
    chk("abort_ready", cpu_ready, 0);
    @(negedge clk) rst_n = 1'b0;
    lat = 1;
    for (int a = 0; a < 2048; a++) refm[a] = l2mem[a];
    b_rd = n_rd;
    cpu_op(0, 11'h150, 0, cyc);
    chk("post_rst_hit", l1_hit, 0);
    chk("post_rst_nrd", n_rd, b_rd + 1);
    chk("post_rst_data", cpu_data_out, refm[11'h150]);

    for (int k = 0; k < 10000; k++) begin
      logic [10:0] a;
      a = 11'($urandom_range(0, 2047));
      cpu_op(0, a, 0, cyc);
      chk("rnd_read", cpu_data_out, refm[a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
